// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes_gearbox family: per-bank state encoding
// and the index-width helper used to size word pointers.
package serdes_pkg;

  // Occupancy of one ping-pong frame bank.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Width of a word index into an n-sample frame (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_gearbox_bank.sv
// One frame buffer of the gearbox: a lane-wide write port at a word index and
// a lane-wide combinational read port. Contents are plain storage, never reset.
module serdes_gearbox_bank
  import serdes_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int N_SAMPLES = 8,
  parameter  int IN_LANES  = 1,
  parameter  int OUT_LANES = 2,
  localparam int IW        = idx_width(N_SAMPLES)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [IW-1:0]                  wr_idx,
  input  logic [IN_LANES*BIT_WIDTH-1:0]  wr_data,
  input  logic [IW-1:0]                  rd_idx,
  output logic [OUT_LANES*BIT_WIDTH-1:0] rd_data
);

  logic [BIT_WIDTH-1:0] mem [N_SAMPLES];

  // Store one input beat; lane l lands at word wr_idx+l.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < IN_LANES; l++) begin
        mem[wr_idx + IW'(l)] <= wr_data[l*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Present OUT_LANES consecutive words starting at rd_idx, lane 0 in the LSBs.
  always_comb begin
    rd_data = '0;
    for (int l = 0; l < OUT_LANES; l++) begin
      rd_data[l*BIT_WIDTH +: BIT_WIDTH] = mem[rd_idx + IW'(l)];
    end
  end

endmodule

// File: rtl/serdes_gearbox.sv
// Width-converting gearbox: IN_LANES samples per input beat are regrouped into
// N_SAMPLES frames held in two ping-pong banks and drained OUT_LANES per beat.
// Optional build macro SERDES_GEARBOX_FLUSH_EN adds recv_flush, which closes a
// partially filled frame early; unfilled slots then read back as zero.
module serdes_gearbox
  import serdes_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int IN_LANES  = 1,
  parameter int OUT_LANES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [IN_LANES*BIT_WIDTH-1:0]  recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
`ifdef SERDES_GEARBOX_FLUSH_EN
  input  logic                           recv_flush,
`endif
  output logic [OUT_LANES*BIT_WIDTH-1:0] send_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic                           send_last
);

  localparam int            IW     = idx_width(N_SAMPLES);
  localparam logic [IW-1:0] W_STEP = IW'(IN_LANES);
  localparam logic [IW-1:0] R_STEP = IW'(OUT_LANES);
  localparam logic [IW-1:0] W_LAST = IW'(N_SAMPLES - IN_LANES);
  localparam logic [IW-1:0] R_LAST = IW'(N_SAMPLES - OUT_LANES);

  if ((N_SAMPLES % IN_LANES) != 0 || (N_SAMPLES % OUT_LANES) != 0) begin : g_bad_cfg
    $error("serdes_gearbox: N_SAMPLES must be a multiple of IN_LANES and OUT_LANES");
  end

  logic                           wbank;
  logic                           rbank;
  logic [IW-1:0]                  widx;
  logic [IW-1:0]                  ridx;
  bank_state_e                    bank_st [2];
  logic [1:0]                     full;
  logic                           in_fire;
  logic                           out_fire;
  logic                           wr_last;
  logic                           rd_last;
  logic                           bank_close;
  logic [OUT_LANES*BIT_WIDTH-1:0] rd_data [2];

  assign full[0]   = (bank_st[0] == BANK_FULL);
  assign full[1]   = (bank_st[1] == BANK_FULL);
  assign recv_rdy  = !full[wbank];
  assign send_val  = full[rbank];
  assign send_last = send_val && (ridx == R_LAST);
  assign in_fire   = recv_val && recv_rdy;
  assign out_fire  = send_val && send_rdy;
  assign wr_last   = in_fire && (widx == W_LAST);
  assign rd_last   = (ridx == R_LAST);

`ifdef SERDES_GEARBOX_FLUSH_EN
  localparam int CW = IW + 1;

  logic [CW-1:0] cnt [2];
  logic          flush_close;

  // A flush only closes a bank that is open for writing and holds at least
  // one sample, including a beat landing in the same cycle.
  assign flush_close = recv_flush && !full[wbank] && (in_fire || (widx != '0));
  assign bank_close  = wr_last || flush_close;

  // Track how many samples of each bank are valid; the value at close time
  // masks the unfilled tail of a flushed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else if (in_fire) begin
      cnt[wbank] <= CW'(widx) + CW'(IN_LANES);
    end
  end
`else
  assign bank_close = wr_last;
`endif

  // Write and read pointers plus bank occupancy; the write side closing one
  // bank and the read side freeing the other never touch the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      widx       <= '0;
      ridx       <= '0;
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      if (bank_close) begin
        bank_st[wbank] <= BANK_FULL;
        wbank          <= ~wbank;
        widx           <= '0;
      end else if (in_fire) begin
        widx <= widx + W_STEP;
      end
      if (out_fire) begin
        if (rd_last) begin
          bank_st[rbank] <= BANK_EMPTY;
          rbank          <= ~rbank;
          ridx           <= '0;
        end else begin
          ridx <= ridx + R_STEP;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    serdes_gearbox_bank #(
      .BIT_WIDTH (BIT_WIDTH),
      .N_SAMPLES (N_SAMPLES),
      .IN_LANES  (IN_LANES),
      .OUT_LANES (OUT_LANES)
    ) u_bank (
      .clk     (clk),
      .wr_en   (in_fire && (wbank == 1'(b))),
      .wr_idx  (widx),
      .wr_data (recv_msg),
      .rd_idx  (ridx),
      .rd_data (rd_data[b])
    );
  end

  // Drive the output beat from the read bank; idle output is forced to zero.
  always_comb begin
    send_msg = '0;
    if (send_val) begin
      send_msg = rd_data[rbank];
`ifdef SERDES_GEARBOX_FLUSH_EN
      for (int l = 0; l < OUT_LANES; l++) begin
        if ((CW'(ridx) + CW'(l)) >= cnt[rbank]) begin
          send_msg[l*BIT_WIDTH +: BIT_WIDTH] = '0;
        end
      end
`endif
    end
  end

endmodule
